// File: rtl/freq_scan_ctrl.sv
// Frame sequencer for the frequency-bin accumulator: scans the magnitude RAM into the
// accumulator write port, then pulses start and reports done; queues one early frame.
module freq_scan_ctrl #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int MAG_W    = 24,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_rdy,
  output logic              mag_rd_en,
  output logic [ADDR_W-1:0] mag_raddr,
  input  logic [MAG_W-1:0]  mag_rdata,
  output logic              cnt_we,
  output logic [ADDR_W-1:0] cnt_addr,
  output logic [MAG_W-1:0]  cnt_mag,
  output logic              cnt_start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, LATCH, SETTLE, DONE} state_t;

  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_POINTS - 1);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(RD_LAT - 1);

  state_t          state_reg;
  logic            pending_reg;
  logic [DCW-1:0]  drain_cnt_reg;
  logic            start_scan;
  logic            queue_frame;

  // A frame that does not immediately start a scan is queued (or dropped if one already waits).
  assign start_scan  = (state_reg == IDLE) && enable && (frame_rdy || pending_reg);
  assign queue_frame = frame_rdy && !start_scan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mag_rd_en     <= 1'b0;
      mag_raddr     <= '0;
      cnt_start     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      cnt_start <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_scan) begin
            state_reg <= SCAN;
            mag_rd_en <= 1'b1;
            mag_raddr <= '0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (mag_raddr == LAST_ADDR) begin
            state_reg     <= DRAIN;
            mag_rd_en     <= 1'b0;
            drain_cnt_reg <= '0;
          end else begin
            mag_raddr <= mag_raddr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Wait for the last read to emerge from the RAM before latching the bins.
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= LATCH;
            cnt_start <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DCW'(1);
          end
        end
        LATCH: begin
          state_reg <= SETTLE;
        end
        SETTLE: begin
          state_reg <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          mag_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (start_scan) begin
      if (!frame_rdy) pending_reg <= 1'b0;
    end else if (queue_frame) begin
      if (!pending_reg) begin
        pending_reg <= 1'b1;
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // Read enable and address are delayed to line up with the RAM data.
  logic [ADDR_W:0] dl_in;
  assign dl_in = {mag_rd_en, mag_raddr};

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_dl
    logic [ADDR_W:0] stage_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= '0;
        else        stage_reg <= dl_in;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= '0;
        else        stage_reg <= g_dl[gi-1].stage_reg;
      end
    end
  end

  assign {cnt_we, cnt_addr} = g_dl[RD_LAT-1].stage_reg;
  assign cnt_mag            = mag_rdata;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Bench for freq_scan_ctrl: directed scenarios plus random frame/enable/reset traffic,
// every cycle checked against a timeline model of scans derived from the accept cycle.
module tb_freq_scan_ctrl;
  localparam int N = 1024;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n, enable, frame_rdy;
  logic        mag_rd_en, cnt_we, cnt_start, busy, done;
  logic [9:0]  mag_raddr, cnt_addr;
  logic [23:0] mag_rdata, cnt_mag;
  logic [7:0]  overrun_cnt;

  freq_scan_ctrl #(.N_POINTS(N), .ADDR_W(10), .MAG_W(24), .RD_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_rdy(frame_rdy),
    .mag_rd_en(mag_rd_en), .mag_raddr(mag_raddr), .mag_rdata(mag_rdata),
    .cnt_we(cnt_we), .cnt_addr(cnt_addr), .cnt_mag(cnt_mag),
    .cnt_start(cnt_start), .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [23:0] mag_of(input int a);
    int sq;
    sq = (a * a) % 8192;
    return 24'((a + 1) | (sq << 11));
  endfunction

  // RAM with RD_LAT cycles of read latency
  logic [23:0] ram_pipe [L];
  always @(posedge clk) begin
    ram_pipe[0] <= mag_of(int'(mag_raddr));
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mag_rdata = ram_pipe[L-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a scan accepted at edge T fixes every output as a function of k = edge - T.
  int e_cnt = 0;
  int m_t = 0;
  bit m_active = 0;
  bit m_pending = 0;
  int m_ovr = 0;
  int m_last_raddr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_pending = 0; m_ovr = 0; m_last_raddr = 0;
    end else begin
      e_cnt++;
      if (m_active && (e_cnt - m_t >= N + L + 4)) m_active = 0;
      if (!m_active && enable && (frame_rdy || m_pending)) begin
        m_t = e_cnt;
        m_active = 1;
        if (!frame_rdy) m_pending = 0;
      end else if (frame_rdy) begin
        if (!m_pending) m_pending = 1;
        else if (m_ovr < 255) m_ovr++;
      end
      if (m_active && (e_cnt - m_t) <= N - 1) m_last_raddr = e_cnt - m_t;
    end
  end

  int  done_count = 0, done_edge = 0, done_prev = 0, start_edge = 0, first_read_edge = 0;
  int  wr_cnt = 0, frame_writes = 0, low_sum = 0;
  logic [23:0] mag3 = '0;
  bit  capture_en = 0;

  always @(posedge clk) begin
    int k;
    bit exp_rd, exp_we, exp_start, exp_done, exp_busy;
    #1;
    if (rst_n) begin
      k         = m_active ? (e_cnt - m_t) : -1;
      exp_busy  = m_active && k >= 0 && k <= N + L + 2;
      exp_rd    = m_active && k >= 0 && k <= N - 1;
      exp_we    = m_active && k >= L && k <= N - 1 + L;
      exp_start = m_active && k == N + L;
      exp_done  = m_active && k == N + L + 2;
      check("busy", 32'(busy), 32'(exp_busy));
      check("mag_rd_en", 32'(mag_rd_en), 32'(exp_rd));
      check("mag_raddr", 32'(mag_raddr), 32'(m_last_raddr));
      check("cnt_we", 32'(cnt_we), 32'(exp_we));
      if (exp_we) begin
        check("cnt_addr", 32'(cnt_addr), 32'(k - L));
        check("cnt_mag", 32'(cnt_mag), 32'(mag_of(k - L)));
      end
      check("cnt_start", 32'(cnt_start), 32'(exp_start));
      check("done", 32'(done), 32'(exp_done));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
      check("we_start_overlap", 32'(cnt_we & cnt_start), 32'd0);
      if (cnt_we) begin
        wr_cnt++;
        if (capture_en && cnt_addr < 10'd68) low_sum += int'(cnt_mag[10:0]);
        if (capture_en && cnt_addr == 10'd3) mag3 = cnt_mag;
      end
      if (mag_rd_en && mag_raddr == 10'd0) first_read_edge = e_cnt + 1;
      if (cnt_start) start_edge = e_cnt + 1;
      if (done) begin
        done_count++;
        done_prev    = done_edge;
        done_edge    = e_cnt + 1;
        frame_writes = wr_cnt;
        wr_cnt       = 0;
        $display("frame %0d done at edge %0d: %0d writes, overrun_cnt=%0d",
                 done_count, done_edge, frame_writes, overrun_cnt);
      end
    end else begin
      wr_cnt = 0;
    end
  end

  task automatic pulse();
    @(negedge clk); frame_rdy = 1'b1;
    @(negedge clk); frame_rdy = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (done_count < target && n < bound) begin @(negedge clk); n++; end
    check("done_timeout", 32'(done_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_active || m_pending) && n < bound) begin @(negedge clk); n++; end
    @(negedge clk);
    check("idle_timeout", 32'(n < bound), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int t1, dc;
    rst_n = 1'b0; enable = 1'b1; frame_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_en", 32'(mag_rd_en), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // single frame, bench RAM word low bits = addr+1
    repeat (5) @(negedge clk);
    capture_en = 1;
    pulse();
    t1 = m_t;
    wait_done(1, N + 100);
    capture_en = 0;
    check("t1_first_read_lat", 32'(first_read_edge - t1), 32'd1);
    check("t1_start_lat", 32'(start_edge - t1), 32'(N + L + 1));
    check("t1_done_lat", 32'(done_edge - t1), 32'(N + L + 3));
    check("t1_writes", 32'(frame_writes), 32'd1024);
    check("t1_bin_sum", 32'(low_sum), 32'd2346);
    check("t1_mag3", 32'(mag3), 32'd18436);
    wait_idle(100);

    // frame arriving 100 cycles into a scan is queued and runs right after DONE
    pulse();
    repeat (100) @(negedge clk);
    pulse();
    wait_done(3, 2 * N + 200);
    check("t2_back_to_back", 32'(first_read_edge - done_prev), 32'd2);
    check("t2_overrun", 32'(overrun_cnt), 32'd0);
    check("t2_writes", 32'(frame_writes), 32'd1024);
    wait_idle(2 * N + 200);

    // three early frames: one queued, two dropped; then saturation
    pulse();
    repeat (20) @(negedge clk);
    repeat (3) pulse();
    @(negedge clk);
    check("t3_overrun2", 32'(overrun_cnt), 32'd2);
    repeat (300) pulse();
    @(negedge clk);
    check("t3_overrun_sat", 32'(overrun_cnt), 32'd255);
    wait_idle(3 * N + 200);

    // disabled: frame held pending until enable returns
    @(negedge clk); enable = 1'b0;
    pulse();
    repeat (5) @(negedge clk);
    check("t4_busy_off", 32'(busy), 32'd0);
    check("t4_no_read", 32'(mag_rd_en), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("t4_busy_on", 32'(busy), 32'd1);
    check("t4_read_on", 32'(mag_rd_en), 32'd1);
    wait_idle(2 * N + 200);

    // reset in the middle of a scan
    pulse();
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rd_en", 32'(mag_rd_en), 32'd0);
    check("t5_we", 32'(cnt_we), 32'd0);
    check("t5_raddr", 32'(mag_raddr), 32'd0);
    check("t5_overrun", 32'(overrun_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = done_count;
    pulse();
    wait_done(dc + 1, N + 100);
    check("t5_writes", 32'(frame_writes), 32'd1024);
    wait_idle(100);

    // random frame / enable / reset traffic
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      frame_rdy = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 7999) != 0);
    end
    @(negedge clk);
    frame_rdy = 1'b0; enable = 1'b1; rst_n = 1'b1;
    wait_idle(3 * N + 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
